// File: rtl/qsn_shift_sequencer_pkg.sv
// Shared definitions for the QSN shift sequencer: source-select encodings,
// FSM states, table entry layout and the source-select decoder.
package qsn_shift_sequencer_pkg;

  localparam int QSN_SEL_W   = 2;
  localparam int QSN_ENTRY_W = 9;

  localparam logic [QSN_SEL_W-1:0] SRC_IN0 = 2'd0;
  localparam logic [QSN_SEL_W-1:0] SRC_IN1 = 2'd1;
  localparam logic [QSN_SEL_W-1:0] SRC_IN2 = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic       inSrc;
    logic [2:0] bit0Src;
  } src_dec_t;

  // The reserved code 3 falls back to the in0 routing.
  function automatic src_dec_t decodeSrc(input logic [QSN_SEL_W-1:0] sel);
    src_dec_t dec;
    case (sel)
      SRC_IN0: dec = '{inSrc: 1'b0, bit0Src: 3'b001};
      SRC_IN1: dec = '{inSrc: 1'b1, bit0Src: 3'b010};
      SRC_IN2: dec = '{inSrc: 1'b1, bit0Src: 3'b100};
      default: dec = '{inSrc: 1'b0, bit0Src: 3'b001};
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/qsn_seq_tag_pipe.sv
// Fixed-depth delay line carrying {valid, tag} so tags line up with the
// permuted data leaving the QSN pipeline.
module qsn_seq_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o
);

  logic [TAG_W:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= {valid_i, tag_i};
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign valid_o = stage_q[DEPTH-1][TAG_W];
  assign tag_o   = stage_q[DEPTH-1][TAG_W-1:0];

endmodule

// File: rtl/qsn_shift_sequencer.sv
// Walks the per-layer submatrix table and issues QSN shift / source-select
// controls with aligned valid/tag. Define QSN_SEQ_SHIFT_CHK_EN for entry checking.
module qsn_shift_sequencer
  import qsn_shift_sequencer_pkg::*;
#(
  parameter int CHECK_PARALLELISM     = 85,
  parameter int BITWIDTH_SHIFT_FACTOR = QSN_ENTRY_W - QSN_SEL_W,
  parameter int LAYER_NUM             = 4,
  parameter int COL_NUM               = 8,
  parameter int PIPE_LAT              = 2,
  parameter int TBL_AW                = 5
) (
  input  logic                                     sys_clk,
  input  logic                                     rst,
  input  logic                                     cfg_we,
  input  logic [TBL_AW-1:0]                        cfg_addr,
  input  logic [BITWIDTH_SHIFT_FACTOR+QSN_SEL_W-1:0] cfg_data,
  input  logic                                     start,
  input  logic                                     stall,
  output logic                                     busy,
  output logic                                     done,
  output logic [BITWIDTH_SHIFT_FACTOR-1:0]         shift_factor,
  output logic                                     sw_in_src,
  output logic [2:0]                               sw_in_bit0_src,
  output logic                                     zero_shift,
  output logic                                     issue_valid,
  output logic                                     out_valid,
  output logic [$clog2(LAYER_NUM)-1:0]             out_layer,
  output logic [$clog2(COL_NUM)-1:0]               out_col,
  output logic                                     cfg_err
);

  localparam int SW        = BITWIDTH_SHIFT_FACTOR;
  localparam int ENTRY_W   = SW + QSN_SEL_W;
  localparam int LW        = $clog2(LAYER_NUM);
  localparam int CW        = $clog2(COL_NUM);
  localparam int DW        = $clog2(PIPE_LAT + 1);
  localparam int TBL_DEPTH = LAYER_NUM * COL_NUM;

  localparam logic [LW-1:0] LAST_LAYER = LW'(LAYER_NUM - 1);
  localparam logic [CW-1:0] LAST_COL   = CW'(COL_NUM - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(PIPE_LAT - 1);

  seq_state_e          state_q, state_d;
  logic [LW-1:0]       layer_q, layer_d, issueLayer_q, issueLayer_d;
  logic [CW-1:0]       col_q, col_d, issueCol_q, issueCol_d;
  logic [DW-1:0]       drainCnt_q, drainCnt_d;
  logic                issueValid_q, issueValid_d;
  logic [SW-1:0]       shift_q, shift_d;
  logic                swInSrc_q, swInSrc_d;
  logic [2:0]          bit0Src_q, bit0Src_d;
  logic                zeroShift_q, zeroShift_d;
  logic                done_q, done_d;

  logic [ENTRY_W-1:0]  tbl_q [TBL_DEPTH];
  logic                tblWe;
  logic [TBL_AW-1:0]   rdAddr;
  logic [ENTRY_W-1:0]  rdEntry;
  logic [SW-1:0]       rdShift, effShift;
  logic [QSN_SEL_W-1:0] rdSel;
  src_dec_t            rdDec;
  logic                issueNow;

  // Writes past the populated table are dropped when the address space is larger.
  if ((2 ** TBL_AW) > TBL_DEPTH) begin : gAddrChk
    assign tblWe = cfg_we && (cfg_addr < TBL_AW'(TBL_DEPTH));
  end else begin : gNoAddrChk
    assign tblWe = cfg_we;
  end

  always_ff @(posedge sys_clk) begin
    if (tblWe) tbl_q[cfg_addr] <= cfg_data;
  end

  assign rdAddr   = TBL_AW'(layer_q) * TBL_AW'(COL_NUM) + TBL_AW'(col_q);
  assign rdEntry  = tbl_q[rdAddr];
  assign rdShift  = rdEntry[SW-1:0];
  assign rdSel    = rdEntry[ENTRY_W-1 -: QSN_SEL_W];
  assign rdDec    = decodeSrc(rdSel);
  assign issueNow = (state_q == RUN) && !stall;

`ifdef QSN_SEQ_SHIFT_CHK_EN
  logic entryBad;
  logic cfgErr_q;

  assign entryBad = (rdShift >= SW'(CHECK_PARALLELISM)) || (&rdSel);
  assign effShift = entryBad ? '0 : rdShift;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                       cfgErr_q <= 1'b0;
    else if (issueNow && entryBad) cfgErr_q <= 1'b1;
  end

  assign cfg_err = cfgErr_q;
`else
  assign effShift = rdShift;
  assign cfg_err  = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    col_d        = col_q;
    drainCnt_d   = drainCnt_q;
    issueValid_d = 1'b0;
    shift_d      = shift_q;
    swInSrc_d    = swInSrc_q;
    bit0Src_d    = bit0Src_q;
    zeroShift_d  = zeroShift_q;
    issueLayer_d = issueLayer_q;
    issueCol_d   = issueCol_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // done_q marks the cycle busy has just dropped; a start there is ignored.
        if (start && !done_q) begin
          state_d = RUN;
          layer_d = '0;
          col_d   = '0;
        end
      end
      RUN: begin
        if (issueNow) begin
          issueValid_d = 1'b1;
          shift_d      = effShift;
          swInSrc_d    = rdDec.inSrc;
          bit0Src_d    = rdDec.bit0Src;
          zeroShift_d  = (effShift == '0);
          issueLayer_d = layer_q;
          issueCol_d   = col_q;
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (layer_q == LAST_LAYER) begin
              layer_d    = '0;
              drainCnt_d = '0;
              state_d    = DRAIN;
            end else begin
              layer_d = layer_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drainCnt_q == LAST_DRAIN) begin
          drainCnt_d = '0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          drainCnt_d = drainCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      layer_q      <= '0;
      col_q        <= '0;
      drainCnt_q   <= '0;
      issueValid_q <= 1'b0;
      shift_q      <= '0;
      swInSrc_q    <= 1'b0;
      bit0Src_q    <= '0;
      zeroShift_q  <= 1'b0;
      issueLayer_q <= '0;
      issueCol_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      col_q        <= col_d;
      drainCnt_q   <= drainCnt_d;
      issueValid_q <= issueValid_d;
      shift_q      <= shift_d;
      swInSrc_q    <= swInSrc_d;
      bit0Src_q    <= bit0Src_d;
      zeroShift_q  <= zeroShift_d;
      issueLayer_q <= issueLayer_d;
      issueCol_q   <= issueCol_d;
      done_q       <= done_d;
    end
  end

  qsn_seq_tag_pipe #(
    .DEPTH (PIPE_LAT),
    .TAG_W (LW + CW)
  ) u_tag_pipe (
    .clk_i   (sys_clk),
    .rst_i   (rst),
    .valid_i (issueValid_q),
    .tag_i   ({issueLayer_q, issueCol_q}),
    .valid_o (out_valid),
    .tag_o   ({out_layer, out_col})
  );

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign shift_factor   = shift_q;
  assign sw_in_src      = swInSrc_q;
  assign sw_in_bit0_src = bit0Src_q;
  assign zero_shift     = zeroShift_q;
  assign issue_valid    = issueValid_q;

endmodule

// File: tb/tb_qsn_shift_sequencer.sv
// Directed bench for qsn_shift_sequencer: full iteration, stall window, mid-run
// reset, ignored starts and table decoding (QSN_SEQ_SHIFT_CHK_EN aware).
module tb_qsn_shift_sequencer;

  localparam int SW       = 7;
  localparam int NENT     = 32;
  localparam int STALL_AT = 21;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0;
  logic [4:0]    cfg_addr = '0;
  logic [SW+1:0] cfg_data = '0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          busy, done, sw_in_src, zero_shift, issue_valid, out_valid, cfg_err;
  logic [SW-1:0] shift_factor;
  logic [2:0]    sw_in_bit0_src;
  logic [1:0]    out_layer;
  logic [2:0]    out_col;

  int vectorCount = 0;
  int missCount   = 0;
  int expSrc [NENT];
  int expRaw [NENT];
  bit errSeen = 1'b0;

  always #5 sys_clk = ~sys_clk;

  qsn_shift_sequencer dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .start          (start),
    .stall          (stall),
    .busy           (busy),
    .done           (done),
    .shift_factor   (shift_factor),
    .sw_in_src      (sw_in_src),
    .sw_in_bit0_src (sw_in_bit0_src),
    .zero_shift     (zero_shift),
    .issue_valid    (issue_valid),
    .out_valid      (out_valid),
    .out_layer      (out_layer),
    .out_col        (out_col),
    .cfg_err        (cfg_err)
  );

  // Single comparison point; every check in the bench is counted here.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic bit entryBad(input int idx);
`ifdef QSN_SEQ_SHIFT_CHK_EN
    return (expRaw[idx] >= 85) || (expSrc[idx] == 3);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int expShift(input int idx);
    return entryBad(idx) ? 0 : expRaw[idx];
  endfunction

  function automatic int expSw(input int idx);
    return (expSrc[idx] == 1 || expSrc[idx] == 2) ? 1 : 0;
  endfunction

  function automatic int expBit0(input int idx);
    if (expSrc[idx] == 1) return 2;
    if (expSrc[idx] == 2) return 4;
    return 1;
  endfunction

  // Entry issued on the sample after edge t of a run (edge 0 takes the start);
  // sLen stalled edges begin at STALL_AT. -1 means nothing issued.
  function automatic int issueIdxAt(input int t, input int sLen);
    int idx;
    if (t < 1) return -1;
    if (t < STALL_AT) return t - 1;
    if (t < STALL_AT + sLen) return -1;
    idx = t - 1 - sLen;
    return (idx < NENT) ? idx : -1;
  endfunction

  task automatic stepCycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input int addr, input int src, input int shift);
    cfg_we   = 1'b1;
    cfg_addr = addr[4:0];
    cfg_data = {src[1:0], shift[SW-1:0]};
    stepCycle();
    cfg_we = 1'b0;
    expSrc[addr] = src;
    expRaw[addr] = shift;
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, " busy"}, busy, 0);
    checkOutput({name, " done"}, done, 0);
    checkOutput({name, " shift"}, shift_factor, 0);
    checkOutput({name, " swsrc"}, sw_in_src, 0);
    checkOutput({name, " bit0"}, sw_in_bit0_src, 0);
    checkOutput({name, " zero"}, zero_shift, 0);
    checkOutput({name, " ivalid"}, issue_valid, 0);
    checkOutput({name, " ovalid"}, out_valid, 0);
    checkOutput({name, " olayer"}, out_layer, 0);
    checkOutput({name, " ocol"}, out_col, 0);
    checkOutput({name, " err"}, cfg_err, 0);
  endtask

  // One iteration with an optional stall window; starts at t=10 (busy) and in
  // the done cycle must both be ignored.
  task automatic runIteration(input int sLen, input string name);
    int idx, lastIdx, oIdx;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    checkOutput($sformatf("%s busy t0", name), busy, 1);
    checkOutput($sformatf("%s ivalid t0", name), issue_valid, 0);
    lastIdx = -1;
    for (int t = 1; t <= 40 + sLen; t++) begin
      stall = (t >= STALL_AT) && (t < STALL_AT + sLen);
      start = (t == 10) || (t == 35 + sLen);
      stepCycle();
      stall = 1'b0;
      start = 1'b0;
      idx = issueIdxAt(t, sLen);
      if (idx >= 0) lastIdx = idx;
      if (idx >= 0 && entryBad(idx)) errSeen = 1'b1;
      checkOutput($sformatf("%s ivalid t%0d", name, t), issue_valid, (idx >= 0) ? 1 : 0);
      if (lastIdx >= 0) begin
        checkOutput($sformatf("%s shift t%0d", name, t), shift_factor, expShift(lastIdx));
        checkOutput($sformatf("%s swsrc t%0d", name, t), sw_in_src, expSw(lastIdx));
        checkOutput($sformatf("%s bit0 t%0d", name, t), sw_in_bit0_src, expBit0(lastIdx));
        checkOutput($sformatf("%s zero t%0d", name, t), zero_shift, (expShift(lastIdx) == 0) ? 1 : 0);
      end
      checkOutput($sformatf("%s err t%0d", name, t), cfg_err, errSeen);
      oIdx = issueIdxAt(t - 2, sLen);
      checkOutput($sformatf("%s ovalid t%0d", name, t), out_valid, (oIdx >= 0) ? 1 : 0);
      if (oIdx >= 0) begin
        checkOutput($sformatf("%s olayer t%0d", name, t), out_layer, oIdx / 8);
        checkOutput($sformatf("%s ocol t%0d", name, t), out_col, oIdx % 8);
      end
      checkOutput($sformatf("%s busy t%0d", name, t), busy, (t <= 33 + sLen) ? 1 : 0);
      checkOutput($sformatf("%s done t%0d", name, t), done, (t == 34 + sLen) ? 1 : 0);
    end
  endtask

  // Reset while issuing in layer 2 must clear everything at once and never pulse done.
  task automatic resetMidRun();
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    repeat (18) stepCycle();
    checkOutput("prerst ivalid", issue_valid, 1);
    checkOutput("prerst shift", shift_factor, expShift(17));
    rst = 1'b1;
    #1;
    errSeen = 1'b0;
    checkAllZero("midrst");
    stepCycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput($sformatf("postrst done c%0d", i), done, 0);
      checkOutput($sformatf("postrst busy c%0d", i), busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) stepCycle();
    checkAllZero("reset");
    rst = 1'b0;
    stepCycle();

    for (int k = 0; k < NENT; k++) applyStimulus(k, k % 3, k * 3);
    applyStimulus(8, 2, 0);

    runIteration(0, "run");
    runIteration(3, "stall");
    resetMidRun();
    applyStimulus(5, 3, 15);
    runIteration(0, "rerun");

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
